param_long_divider: RTL and testbench

Multi-cycle restoring long divider, the parametrised successor to the team's fixed unsigned divider. It adds:
- a per-operation signed/unsigned mode,
- divide-by-zero and signed-overflow flags,
- a busy indication,
- a deterministic latency derived from WIDTH.

It sits behind datapath control logic that issues one start_op pulse per operation and consumes the results on done.

---
 rtl/param_long_divider_if.sv | 27 ++
 rtl/param_long_divider.sv | 114 +++++++++++
 tb/tb_param_long_divider.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/param_long_divider_if.sv
// Operand/result bundle between datapath control and the long divider.
// Handshake: start_op is taken only while busy=0; done pulses once per accepted operation and the results/flags hold until the next done.
interface param_long_divider_if #(
    parameter int WIDTH = 16
);
    logic             start_op;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             done;
    logic             busy;
    logic             div_by_zero;
    logic             overflow;
    logic [1:0]       state_dbg;

    modport master (
        output start_op, signed_op, dividend, divisor,
        input  quotient, remainder, done, busy, div_by_zero, overflow, state_dbg
    );

    modport slave (
        input  start_op, signed_op, dividend, divisor,
        output quotient, remainder, done, busy, div_by_zero, overflow, state_dbg
    );
endinterface

// File: rtl/param_long_divider.sv
// Multi-cycle restoring divider, signed or unsigned per operation, fixed latency of WIDTH+3 edges
// (divide-by-zero short-cuts to a single edge after accept).
module param_long_divider #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    param_long_divider_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] dvd_r, dvs_r, dvs_mag, quot, rem;
    logic             signed_r, sign_q, sign_r, dbz_r, ovf_r;
    logic [WIDTH-1:0] quotient_r, remainder_r;
    logic             done_r, dbz_out, ovf_out;

    logic [WIDTH:0]   rem_sh;
    logic             ge;
    logic [WIDTH-1:0] rem_next, dvd_abs, dvs_abs, quot_fix, rem_fix;

    always_comb begin
        // The shifted partial remainder needs WIDTH+1 bits; after the trial
        // subtraction it is always below the divisor and fits in WIDTH bits.
        rem_sh   = {rem, quot[WIDTH-1]};
        ge       = (rem_sh >= {1'b0, dvs_mag});
        rem_next = ge ? (rem_sh[WIDTH-1:0] - dvs_mag) : rem_sh[WIDTH-1:0];
        dvd_abs  = dvd_r[WIDTH-1] ? -dvd_r : dvd_r;
        dvs_abs  = dvs_r[WIDTH-1] ? -dvs_r : dvs_r;
        quot_fix = sign_q ? -quot : quot;
        rem_fix  = sign_r ? -rem : rem;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            count       <= '0;
            dvd_r       <= '0;
            dvs_r       <= '0;
            dvs_mag     <= '0;
            quot        <= '0;
            rem         <= '0;
            signed_r    <= 1'b0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            done_r      <= 1'b0;
            dbz_out     <= 1'b0;
            ovf_out     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start_op) begin
                        dvd_r    <= bus.dividend;
                        dvs_r    <= bus.divisor;
                        signed_r <= bus.signed_op;
                        dbz_r    <= (bus.divisor == '0);
                        ovf_r    <= bus.signed_op && (bus.dividend == MIN_VAL) && (bus.divisor == '1);
                        state    <= (bus.divisor == '0) ? S_FIX : S_PREP;
                    end
                end
                S_PREP: begin
                    // |MIN| = 2^(WIDTH-1) is exact when read back as unsigned.
                    quot    <= signed_r ? dvd_abs : dvd_r;
                    dvs_mag <= signed_r ? dvs_abs : dvs_r;
                    rem     <= '0;
                    sign_q  <= signed_r & (dvd_r[WIDTH-1] ^ dvs_r[WIDTH-1]);
                    sign_r  <= signed_r & dvd_r[WIDTH-1];
                    count   <= '0;
                    state   <= S_ITER;
                end
                S_ITER: begin
                    rem   <= rem_next;
                    quot  <= {quot[WIDTH-2:0], ge};
                    count <= count + 1'b1;
                    if (count == LAST) state <= S_FIX;
                end
                default: begin
                    if (dbz_r) begin
                        quotient_r  <= '1;
                        remainder_r <= dvd_r;
                    end else begin
                        quotient_r  <= quot_fix;
                        remainder_r <= rem_fix;
                    end
                    dbz_out <= dbz_r;
                    ovf_out <= ovf_r;
                    done_r  <= 1'b1;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.done        = done_r;
    assign bus.busy        = (state != S_IDLE);
    assign bus.div_by_zero = dbz_out;
    assign bus.overflow    = ovf_out;
    assign bus.state_dbg   = state;
endmodule

// File: tb/tb_param_long_divider.sv
// Directed and randomised checks of param_long_divider (WIDTH=16) against an
// integer-arithmetic reference, with an expected-result queue.
module tb_param_long_divider;
    localparam int W  = 16;
    localparam int EW = 2 * W + 2;

    typedef struct {
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    param_long_divider_if #(.WIDTH(W)) bus ();
    param_long_divider #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [EW-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int done_cnt = 0;
    int n_exp_done = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q, r;
        logic dbz, ovf;
        longint sa, sb;
        dbz = 1'b0;
        ovf = 1'b0;
        if (b == '0) begin
            q = '1;
            r = a;
            dbz = 1'b1;
        end else if (sgn) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            q = W'(sa / sb);
            r = W'(sa % sb);
            ovf = (a == 16'h8000) && (b == 16'hFFFF);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r, dbz, ovf};
    endfunction

    // Must be entered while the divider is idle (or in its done cycle); returns #1 after the accept edge.
    task automatic drive_start(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start_op  = 1'b1;
        bus.signed_op = sgn;
        bus.dividend  = a;
        bus.divisor   = b;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        bus.start_op  = 1'b0;
        bus.signed_op = 1'($urandom);
        bus.dividend  = W'($urandom);
        bus.divisor   = W'($urandom);
        check("busy_after_accept", 64'(bus.busy), 64'd1);
    endtask

    // Latency is counted in edges after the accept edge: WIDTH+2 normally
    // (WIDTH+3 edges including the accept edge), 1 for divide-by-zero.
    task automatic wait_done(input int exp_lat);
        logic [EW-1:0] e;
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (!seen && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done === 1'b1) seen = 1;
        end
        if (!seen) begin
            check("done_timeout", 64'd0, 64'd1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check("latency", 64'(cyc - acc_cyc), 64'(exp_lat));
            check("quotient", 64'(bus.quotient), 64'(e[EW-1 -: W]));
            check("remainder", 64'(bus.remainder), 64'(e[W+1 -: W]));
            check("div_by_zero", 64'(bus.div_by_zero), 64'(e[1]));
            check("overflow", 64'(bus.overflow), 64'(e[0]));
            check("busy_at_done", 64'(bus.busy), 64'd0);
        end
    endtask

    task automatic run_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b, input logic [EW-1:0] exp);
        exp_q.push_back(exp);
        n_exp_done++;
        drive_start(sgn, a, b);
        wait_done((b == '0) ? 1 : W + 2);
    endtask

    vec_t vecs[7] = '{
        '{1'b0, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 1'b0},
        '{1'b1, 16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0},
        '{1'b1, 16'h0064, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0},
        '{1'b0, 16'h0005, 16'h0000, 16'hFFFF, 16'h0005, 1'b1, 1'b0},
        '{1'b1, 16'hFFFB, 16'h0000, 16'hFFFF, 16'hFFFB, 1'b1, 1'b0},
        '{1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1},
        '{1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 1'b0}
    };

    initial begin
        logic [W-1:0] a, b;
        bit saw_done;
        int sel;

        // reset state
        rst = 1'b1;
        bus.start_op = 1'b0;
        bus.signed_op = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_quotient", 64'(bus.quotient), 64'd0);
        check("rst_remainder", 64'(bus.remainder), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_flags", 64'({bus.div_by_zero, bus.overflow}), 64'd0);
        check("rst_state", 64'(bus.state_dbg), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // directed vectors, issued back-to-back on each done cycle
        foreach (vecs[i])
            run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, {vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].ovf});

        // done is a one-cycle pulse and results hold afterwards
        @(posedge clk);
        #1;
        check("done_single_cycle", 64'(bus.done), 64'd0);
        check("remainder_held", 64'(bus.remainder), 64'h8000);

        // start while busy is ignored
        exp_q.push_back({16'd14, 16'd2, 1'b0, 1'b0});
        n_exp_done++;
        drive_start(1'b0, 16'd100, 16'd7);
        repeat (4) @(posedge clk);
        #1;
        bus.start_op = 1'b1;
        bus.signed_op = 1'b1;
        bus.dividend = 16'h1234;
        bus.divisor = 16'h0003;
        @(posedge clk);
        #1;
        bus.start_op = 1'b0;
        wait_done(W + 2);

        // reset on cycle 8 of an operation aborts it without a done pulse
        @(posedge clk);
        #1;
        drive_start(1'b0, 16'd1000, 16'd9);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_quotient", 64'(bus.quotient), 64'd0);
        check("abort_remainder", 64'(bus.remainder), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_flags", 64'({bus.div_by_zero, bus.overflow}), 64'd0);
        saw_done = 0;
        repeat (W + 6) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) saw_done = 1;
        end
        check("no_done_after_abort", 64'(saw_done), 64'd0);

        // random sweep, back-to-back, unsigned then signed
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 1000; k++) begin
                a = W'($urandom);
                b = W'($urandom);
                sel = $urandom_range(0, 15);
                if (sel == 0) b = '0;
                else if (sel == 1) begin a = 16'h8000; b = 16'hFFFF; end
                else if (sel == 2) b = W'($urandom_range(1, 15));
                else if (sel == 3) a = 16'h8000;
                else if (sel == 4) b = 16'hFFFF;
                run_op(m[0], a, b, model(m[0], a, b));
            end
        end

        repeat (2) @(negedge clk);
        check("done_count", 64'(done_cnt), 64'(n_exp_done));
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
